// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int SADD_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sadd_state_t;

endpackage

// File: rtl/full_adder_dataflow.sv
// One-bit full-adder cell, purely combinational; the serial adder's datapath.
module full_adder_dataflow (
  output logic sum,
  output logic carry_out,
  input  logic a,
  input  logic b,
  input  logic carry_in
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: one full-adder cell sequenced LSB-first, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SADD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sadd_state_t      state_q,   state_d;
  logic [WIDTH-1:0] a_sh_q,    a_sh_d;
  logic [WIDTH-1:0] b_sh_q,    b_sh_d;
  logic [WIDTH-1:0] sum_sh_q,  sum_sh_d;
  logic             carry_q,   carry_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q,     ovf_d;
`endif

  logic fa_sum;
  logic fa_co;

  full_adder_dataflow u_fa (
    .sum      (fa_sum),
    .carry_out(fa_co),
    .a        (a_sh_q[0]),
    .b        (b_sh_q[0]),
    .carry_in (carry_q)
  );

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    carry_d   = carry_q;
    bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d     = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d    = a;
          b_sh_d    = b;
          carry_d   = carry_in;
          bit_cnt_d = '0;
          state_d   = RUN;
        end
      end

      RUN: begin
        // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        sum_sh_d  = {fa_sum, sum_sh_q[WIDTH-1:1]};
        carry_d   = fa_co;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      carry_q   <= 1'b0;
      bit_cnt_q <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      carry_q   <= carry_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_sh_q;
  assign carry_out = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: directed vectors with hand-computed results.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       carry_in = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] sum;
  logic       carry_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic       overflow;
`endif

  typedef struct packed {
    logic [7:0] sum;
    logic       co;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   acc_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  logic ov_prev = 1'b0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry_out(carry_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: latency on each rising out_valid, result compare on each handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && !ov_prev) check("latency", cyc - last_acc, WIDTH);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got sum 0x%0h with no result pending", sum);
        end else begin
          mon_e = sb_q.pop_front();
          check("sum", sum, mon_e.sum);
          check("carry_out", carry_out, mon_e.co);
`ifdef SERIAL_ADDER_OVF_EN
          check("overflow", overflow, mon_e.ovf);
`endif
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                      input logic [7:0] es, input logic eco, input logic eovf,
                      input bit keep_valid);
    int n = 0;
    a        = va;
    b        = vb;
    carry_in = vc;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    last_acc = cyc;
    acc_log.push_back(cyc);
    sb_q.push_back('{sum: es, co: eco, ovf: eovf});
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_wait", 32'(out_valid), 1);
  endtask

  initial begin
    int   base;
    int   n;
    logic spurious;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_carry_out", 32'(carry_out), 0);

    // Zero operands: one-cycle out_valid, then idle.
    send(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_out_valid();
    @(negedge clk);
    check("pulse_out_valid_low", 32'(out_valid), 0);
    check("pulse_in_ready_high", 32'(in_ready), 1);

    send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    wait_out_valid();
    @(negedge clk);
    send(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    wait_out_valid();
    @(negedge clk);
    send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    wait_out_valid();
    @(negedge clk);
    send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    wait_out_valid();

    // Back-pressure with a competing request that must be ignored.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
    wait_out_valid();
    a        = 8'hFF;
    b        = 8'h00;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_sum", 32'(sum), 32'h46);
      check("bp_carry_out", 32'(carry_out), 0);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 1);
    check("bp_release_out_valid", 32'(out_valid), 0);

    // Reset while bit_cnt == 3.
    send(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    void'(sb_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_sum", 32'(sum), 0);
    check("abort_carry_out", 32'(carry_out), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    spurious = 1'b0;
    repeat (20) begin
      @(negedge clk);
      spurious = spurious | out_valid;
    end
    check("abort_no_spurious", 32'(spurious), 0);

    // Back-to-back with in_valid and out_ready held high.
    base = acc_log.size();
    send(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
    send(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
    send(8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    check("b2b_spacing_1", acc_log[base+1] - acc_log[base], WIDTH + 2);
    check("b2b_spacing_2", acc_log[base+2] - acc_log[base+1], WIDTH + 2);

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
